decimator: RTL
==============

Name: decimator

Overview:
- Programmable integer down-sampler that sits directly downstream of the FIR filter stage.
- Consumes the filter's out_data/out_nd/out_m stream and keeps one sample in every D. The factor D is set at run time over the shared message bus.
- Messages are forwarded unchanged to the next stage in the message daisy chain.
- Together, filter + decimator form a decimating channel filter.

Parameters:
- WIDTH, 32, sample width in bits (complex: re/im halves), passed through untouched.
- MWIDTH, 1, width of sideband meta signal carried with each sample.
- MAXDEC, 16, largest legal decimation factor.
- DEFAULT_DEC, 1, decimation factor after reset; must satisfy 1 <= DEFAULT_DEC <= MAXDEC.
- ID, 0, 8-bit block identifier; message headers addressed to ID reconfigure this block.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- in_data  in  WIDTH  input sample (filter output).
- in_nd  in  1  in_data valid this cycle.
- in_m  in  MWIDTH  meta bits accompanying in_data.
- in_msg  in  `MSG_WIDTH  message word.
- in_msg_nd  in  1  in_msg valid this cycle.
- out_data  out  WIDTH  kept sample.
- out_nd  out  1  out_data valid (single-cycle pulse per kept sample).
- out_m  out  MWIDTH  meta bits of kept sample.
- out_msg  out  `MSG_WIDTH  forwarded message word.
- out_msg_nd  out  1  forwarded message valid.
- error  out  1  sticky configuration error flag.

Behaviour:
- Reset (async, rst_n=0):
  - out_data=0, out_nd=0, out_m=0, out_msg=0, out_msg_nd=0, error=0.
  - factor=DEFAULT_DEC, phase counter=0, message FSM=IDLE.
  - Reset mid-operation discards any partial configuration and the current phase.
- Sample path: registered, latency 1 cycle.
  - On clk with in_nd=1: if phase==0, next cycle out_nd=1, out_data=in_data, out_m=in_m. Otherwise out_nd=0.
  - Phase then becomes (phase==factor-1) ? 0 : phase+1.
  - With in_nd=0, phase holds and out_nd=0.
  - out_data/out_m hold their last kept value when out_nd=0.
  - The first valid input after reset or after a factor load is always kept.
  - factor=1 passes every sample, i.e. out_nd equals in_nd delayed by one cycle.
- Phase counter: width ceil(log2(MAXDEC)), minimum 1 bit.
- Message forwarding: every cycle, out_msg<=in_msg and out_msg_nd<=in_msg_nd (1-cycle delay). This includes words consumed by this block.
- Message FSM, evaluated only when in_msg_nd=1:
  - IDLE: a header word (bit `MSG_WIDTH-1 = 1) with bits [7:0]==ID goes to WAIT_VAL. Any other word stays in IDLE.
  - WAIT_VAL, header word received: error<=1. If that header's ID matches, stay in WAIT_VAL; otherwise go to IDLE.
  - WAIT_VAL, data word (MSB=0), value V = bits [`MSG_WIDTH-2:0]:
    - If 1 <= V <= MAXDEC: factor<=V, phase<=0.
    - Else: error<=1 and factor is unchanged.
    - In both cases go to IDLE.
- Simultaneous events: when a valid factor load and in_nd=1 occur in the same cycle, the sample is judged with the old phase/factor. The load then takes priority, so phase=0 after that edge.
- error is sticky and clears only on reset. Errors do not stall the sample path or message forwarding.

Test Plan:
- Reset with DEFAULT_DEC=1, drive 8 consecutive in_nd samples 0..7 -> out_nd high 8 cycles, each one cycle late, out_data 0..7; out_m follows in_m.
- Send header {1,..,ID} then data 4, then 12 valid samples 10..21 with in_nd gaps -> outputs exactly 10,14,18; gaps do not advance phase; out_msg echoes both words 1 cycle later.
- With factor=3 mid-stream at phase 2, load factor 2 with in_nd=1 in the same cycle as the data word -> that sample dropped (old phase 2); next sample kept; thereafter every 2nd sample kept; error=0.
- Send header for ID, then data 0, then header for ID plus data MAXDEC+1 -> error=1 after first bad word, factor unchanged, stays 1 after later valid load.
- Send header with ID+1 then data 5 -> factor unchanged, error=0, both words forwarded on out_msg.
- Assert rst_n low asynchronously between clock edges while in WAIT_VAL with phase=2 -> outputs 0 immediately; after release the first sample is kept at factor DEFAULT_DEC.

Source files
------------

// File: rtl/decimator.sv
//----------------------------------------------------------------------------
// decimator
//
// Programmable integer down-sampler placed after the FIR filter stage. Of
// every `factor` valid input samples it keeps the first one and drops the
// rest. The factor is loaded at run time through the shared message bus:
// a header word addressed to ID followed by a data word carrying the new
// factor. All message words are forwarded, one cycle late, to the next block
// in the daisy chain, including the words this block consumes.
//
// Ports
//   clk          clock
//   rst_n        asynchronous active-low reset
//   in_data      input sample (filter output), passed through untouched
//   in_nd        in_data valid this cycle
//   in_m         sideband meta bits travelling with in_data
//   in_msg       message word (MSB=1 header, MSB=0 data)
//   in_msg_nd    in_msg valid this cycle
//   out_data     last kept sample (holds while out_nd=0)
//   out_nd       one-cycle pulse per kept sample
//   out_m        meta bits of the last kept sample
//   out_msg      in_msg delayed by one cycle
//   out_msg_nd   in_msg_nd delayed by one cycle
//   error        sticky configuration error, cleared only by reset
//----------------------------------------------------------------------------
`ifndef MSG_WIDTH
`define MSG_WIDTH 32
`endif

module decimator #(
   parameter int          WIDTH       = 32,
   parameter int          MWIDTH      = 1,
   parameter int          MAXDEC      = 16,
   parameter int          DEFAULT_DEC = 1,
   parameter logic [7:0]  ID          = 8'd0
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic [WIDTH-1:0]       in_data,
   input  logic                   in_nd,
   input  logic [MWIDTH-1:0]      in_m,
   input  logic [`MSG_WIDTH-1:0]  in_msg,
   input  logic                   in_msg_nd,
   output logic [WIDTH-1:0]       out_data,
   output logic                   out_nd,
   output logic [MWIDTH-1:0]      out_m,
   output logic [`MSG_WIDTH-1:0]  out_msg,
   output logic                   out_msg_nd,
   output logic                   error
);

   // Phase only counts 0..MAXDEC-1; the factor register must hold MAXDEC itself.
   localparam int PW = (MAXDEC > 1) ? $clog2(MAXDEC) : 1;
   localparam int FW = $clog2(MAXDEC + 1);
   localparam int VW = `MSG_WIDTH - 1;

   localparam logic [FW-1:0] DEF_FACTOR = FW'(DEFAULT_DEC);
   localparam logic [VW-1:0] MAX_VALUE  = VW'(MAXDEC);

   typedef enum logic {
      ST_IDLE,
      ST_WAIT_VAL
   } msg_state_t;

   // -------------------------------------------------------------------------
   // State
   // -------------------------------------------------------------------------
   msg_state_t               r_state;
   logic [FW-1:0]            r_factor;
   logic [PW-1:0]            r_phase;
   logic                     r_error;
   logic [WIDTH-1:0]         r_out_data;
   logic                     r_out_nd;
   logic [MWIDTH-1:0]        r_out_m;
   logic [`MSG_WIDTH-1:0]    r_out_msg;
   logic                     r_out_msg_nd;

   // -------------------------------------------------------------------------
   // Message decode
   // -------------------------------------------------------------------------
   logic                     w_is_hdr;
   logic                     w_id_hit;
   logic [VW-1:0]            w_value;
   logic                     w_value_ok;

   assign w_is_hdr   = in_msg[`MSG_WIDTH-1];
   assign w_id_hit   = (in_msg[7:0] == ID);
   assign w_value    = in_msg[VW-1:0];
   assign w_value_ok = (w_value != '0) && (w_value <= MAX_VALUE);

   msg_state_t               w_state_nxt;
   logic                     w_load;
   logic                     w_err_set;

   // NOTE: every signal written here gets a default first, so no path through
   // the case statement leaves one unassigned and infers a latch.
   always_comb begin
      w_state_nxt = r_state;
      w_load      = 1'b0;
      w_err_set   = 1'b0;
      if (in_msg_nd) begin
         case (r_state)
            ST_IDLE: begin
               if (w_is_hdr && w_id_hit) begin
                  w_state_nxt = ST_WAIT_VAL;
               end
            end
            ST_WAIT_VAL: begin
               if (w_is_hdr) begin
                  // Header arrived where a value was expected. A fresh header
                  // for us restarts the wait; any other header abandons it.
                  w_err_set   = 1'b1;
                  w_state_nxt = w_id_hit ? ST_WAIT_VAL : ST_IDLE;
               end else begin
                  if (w_value_ok) begin
                     w_load = 1'b1;
                  end else begin
                     w_err_set = 1'b1;
                  end
                  w_state_nxt = ST_IDLE;
               end
            end
         endcase
      end
   end

   // NOTE: sequential state uses non-blocking assignments only, so every
   // register in this block samples the pre-edge values of the others.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state  <= ST_IDLE;
         r_factor <= DEF_FACTOR;
         r_error  <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         if (w_load) begin
            r_factor <= FW'(w_value);
         end
         if (w_err_set) begin
            r_error <= 1'b1;
         end
      end
   end

   // -------------------------------------------------------------------------
   // Sample path
   // -------------------------------------------------------------------------
   logic                     w_keep;
   logic                     w_phase_wrap;

   // A sample is judged against the phase/factor in force before this edge;
   // a factor load on the same edge only affects what follows.
   assign w_keep       = in_nd && (r_phase == '0);
   assign w_phase_wrap = (FW'(r_phase) == (r_factor - FW'(1)));

   // NOTE: the output data registers are reset as well, because the reset
   // value of out_data/out_m is observable and must be zero.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_phase    <= '0;
         r_out_nd   <= 1'b0;
         r_out_data <= '0;
         r_out_m    <= '0;
      end else begin
         r_out_nd <= w_keep;
         if (w_keep) begin
            r_out_data <= in_data;
            r_out_m    <= in_m;
         end
         // A factor load restarts the phase so the next valid sample is kept.
         if (w_load) begin
            r_phase <= '0;
         end else if (in_nd) begin
            r_phase <= w_phase_wrap ? '0 : (r_phase + PW'(1));
         end
      end
   end

   // -------------------------------------------------------------------------
   // Message forwarding: unconditional one-cycle delay of the whole bus
   // -------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_out_msg    <= '0;
         r_out_msg_nd <= 1'b0;
      end else begin
         r_out_msg    <= in_msg;
         r_out_msg_nd <= in_msg_nd;
      end
   end

   assign out_data   = r_out_data;
   assign out_nd     = r_out_nd;
   assign out_m      = r_out_m;
   assign out_msg    = r_out_msg;
   assign out_msg_nd = r_out_msg_nd;
   assign error      = r_error;

endmodule
